div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative 32-bit divider serving the EX stage for DIV/DIVU.
- EX is the initiator: it raises start with operands and holds them.
- div_unit responds after a fixed multi-cycle latency with {remainder, quotient}, which EX writes to HI/LO.
- EX stalls the pipeline while start=1 and ready=0; it may cancel an operation with annul.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width (must hold DATA_W).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- signed_div  input  1  1 = signed division (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1  input  32  dividend; sampled with start
- opdata2  input  32  divisor; sampled with start
- start  input  1  request; held high by EX until ready is seen
- annul  input  1  cancel the request in progress
- result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready  output  1  result valid

Behaviour:
- All outputs are registered. On reset: state=IDLE, ready=0, result=0, counter=0, internal operands=0. Reset mid-operation discards all work.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - If start=1 and annul=0 at edge E0:
    - Go to BYZERO if opdata2==0.
    - Otherwise, latch |opdata1| and |opdata2| (absolute values only when signed_div=1, else raw), latch sign info, clear counter, go to ON.
  - If annul=1, stay in IDLE regardless of start.
  - ready=0, result=0 while in IDLE.
- BYZERO: at the next edge go to END with result=0 and ready=1. Total latency: 2 edges from E0.
- ON: one restoring-division step per clock (shift partial remainder left, trial subtract divisor, set quotient bit).
  - The counter increments each step. After the 32nd step (edge E32) go to END.
  - At that same edge, register the sign-corrected result and set ready=1.
  - annul=1 at any edge in ON: go to IDLE, ready stays 0, result stays 0.
  - start dropping while in ON is ignored; operands were latched at E0.
- Sign correction (signed_div=1 only):
  - Quotient is negated (two's complement) if operand signs differ.
  - Remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap, no exception).
- END:
  - ready=1 and result is held stable while start=1.
  - When start=0 is sampled: go to IDLE, ready=0, result=0.
  - annul in END is ignored.
  - start held high in END never restarts an operation; a new operation needs start low for at least one edge.
- Simultaneous reset and any input: reset wins.

Decomposition:
- Shared package (cpu_defs_pkg):
  - state encoding DIV_IDLE/DIV_BYZERO/DIV_ON/DIV_END
  - EX opcode constants OP_DIV=8'b00011010, OP_DIVU=8'b00011011
  - DATA_W constant
  - HI/LO slice positions of result
- One natural combinational sub-module, div_step: a single restoring iteration taking {partial remainder, dividend bits} and divisor, returning the next partial remainder and quotient bit.

Test Plan:
- Unsigned 7/2 (signed_div=0, opdata1=7, opdata2=2, start held) -> ready rises at edge E32, result={32'h1, 32'h3}; ready stays high until start drops, then 0 the next edge.
- Signed -7/2 (opdata1=0xFFFFFFF9, opdata2=2) -> result={0xFFFFFFFF, 0xFFFFFFFD}; signed 0x80000000/0xFFFFFFFF -> result={0x00000000, 0x80000000}.
- Unsigned 0xFFFFFFFF/0x10 -> result={0x0000000F, 0x0FFFFFFF}; the same operands with signed_div=1 -> {0xFFFFFFFF, 0x00000000}.
- Divide by zero (opdata2=0) -> ready=1 two edges after start, result=0.
- annul pulsed at edge E10 -> back to IDLE, ready never asserts; drop start one cycle, then start 100/7 -> result={2, 14} at the new E32.
- reset asserted at edge E20 mid-divide -> ready=0, result=0 at that edge; a fresh start afterwards completes normally with correct latency.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the EX-stage divider: widths, FSM encoding,
// EX opcodes and the HI/LO split of the 64-bit result.
package cpu_defs_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  // {remainder, quotient}: remainder goes to HI, quotient goes to LO.
  localparam int HI_MSB = 2 * DATA_W - 1;
  localparam int HI_LSB = DATA_W;
  localparam int LO_MSB = DATA_W - 1;
  localparam int LO_LSB = 0;

  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  // Two's complement negation at operand width.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

  // Magnitude of v when treated as signed; raw value for unsigned division.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? negate(v) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider request/response bundle.
// Handshake: EX (master) raises start with operands and keeps start high
// until it observes ready=1; the divider (slave) then holds ready and result
// stable for as long as start stays high, and clears both on the edge that
// samples start=0. annul from the master cancels an operation in progress.
interface div_unit_if;
  import cpu_defs_pkg::*;

  logic                signed_div;
  logic [DATA_W-1:0]   opdata1;
  logic [DATA_W-1:0]   opdata2;
  logic                start;
  logic                annul;
  logic [2*DATA_W-1:0] result;
  logic                ready;
  div_state_t          dbg_state;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, dbg_state
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, dbg_state
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it
// did not go negative.
module div_step
  import cpu_defs_pkg::*;
(
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_bit,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_qbit
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in DATA_W+1 bits and bit DATA_W of the difference is the borrow.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_diff[DATA_W];
  assign o_rem   = o_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider for DIV/DIVU. Operands are latched as magnitudes
// at the accepting edge, 32 restoring steps run one per clock, and the sign
// correction is applied while the final step is registered.
module div_unit
  import cpu_defs_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  div_unit_if.slave bus
);

  div_state_t          r_state;
  div_state_t          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_dvd;
  logic [DATA_W-1:0]   r_dvs;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;
  logic [2*DATA_W-1:0] w_result_nxt;
  logic [2*DATA_W-1:0] w_result_fin;
  logic                w_ready_nxt;
  logic                w_accept;
  logic                w_last;
  logic                w_qbit;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_quo;

  assign w_accept = bus.start && !bus.annul;
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  // r_dvd shifts dividend bits out of its MSB while quotient bits enter the LSB.
  div_step u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[DATA_W-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem),
    .o_qbit    (w_qbit)
  );

  assign w_quo = {r_dvd[DATA_W-2:0], w_qbit};

  // Sign-corrected result of the final step: quotient negative when operand
  // signs differ, remainder follows the dividend sign. 0x80000000/-1 wraps.
  always_comb begin
    w_result_fin = '0;
    w_result_fin[HI_MSB:HI_LSB] = r_neg_r ? negate(w_rem) : w_rem;
    w_result_fin[LO_MSB:LO_LSB] = r_neg_q ? negate(w_quo) : w_quo;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (w_accept) w_state_nxt = (bus.opdata2 == '0) ? DIV_BYZERO : DIV_ON;
      end
      DIV_BYZERO: w_state_nxt = DIV_END;
      DIV_ON: begin
        if (bus.annul)   w_state_nxt = DIV_IDLE;
        else if (w_last) w_state_nxt = DIV_END;
      end
      DIV_END: begin
        if (!bus.start) w_state_nxt = DIV_IDLE;
      end
      default: w_state_nxt = DIV_IDLE;
    endcase
  end

  // Next values of the registered outputs: valid only while heading into END.
  always_comb begin
    w_ready_nxt  = (w_state_nxt == DIV_END);
    w_result_nxt = '0;
    if (w_state_nxt == DIV_END) begin
      if (r_state == DIV_ON)       w_result_nxt = w_result_fin;
      else if (r_state == DIV_END) w_result_nxt = r_result;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready  <= 1'b0;
      r_result <= '0;
    end else begin
      r_ready  <= w_ready_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Operand latch on acceptance and one iteration per clock while ON.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept && (bus.opdata2 != '0)) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= abs_val(bus.opdata1, bus.signed_div);
            r_dvs   <= abs_val(bus.opdata2, bus.signed_div);
            r_neg_q <= bus.signed_div && (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
            r_neg_r <= bus.signed_div && bus.opdata1[DATA_W-1];
          end
        end
        DIV_ON: begin
          if (!bus.annul) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_rem <= w_rem;
            r_dvd <= w_quo;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.result    = r_result;
  assign bus.dbg_state = r_state;

endmodule
